// File: rtl/ofdm_bit_sink.sv
// Bit-to-word back end for the OFDM receiver: recovers the descrambler seed, drops
// service bits, packs payload bits into words and queues them in a small FWFT FIFO.
module ofdm_bit_sink #(
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 do_descramble,
    input  logic [4:0]           skip_bits,
    input  logic [CNT_WIDTH-1:0] num_bits,
    input  logic                 bit_in,
    input  logic                 bit_in_stb,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] bits_delivered
);

    localparam int PC_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FC_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        SKIP = 2'd2,
        DATA = 2'd3
    } state_t;

    // Reset asserts asynchronously, releases two clock edges after reset goes high.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    state_t                state_reg;
    logic [6:0]            scr_reg;
    logic [2:0]            seed_cnt_reg;
    logic [4:0]            skip_cnt_reg;
    logic [4:0]            skip_len_reg;
    logic [CNT_WIDTH-1:0]  num_bits_reg;
    logic                  desc_reg;
    logic [CNT_WIDTH-1:0]  bits_delivered_reg;
    logic [OUT_WIDTH-1:0]  pack_reg;
    logic [PC_W-1:0]       pack_cnt_reg;
    logic                  push_vld_reg;
    logic                  push_last_reg;
    logic [OUT_WIDTH-1:0]  push_data_reg;
    logic                  busy_reg;

    logic                  stb;
    logic                  fb;
    logic                  d_bit;
    logic [6:0]            scr_desc;
    logic [CNT_WIDTH-1:0]  bits_inc;
    logic                  last_bit;
    logic                  word_done;
    logic [OUT_WIDTH-1:0]  pack_next;

    assign stb      = enable & bit_in_stb & ~start;
    assign fb       = scr_reg[6] ^ scr_reg[3];
    assign d_bit    = desc_reg ? (bit_in ^ fb) : bit_in;
    assign scr_desc = desc_reg ? {scr_reg[5:0], fb} : scr_reg;
    assign bits_inc = bits_delivered_reg + CNT_WIDTH'(1);
    assign last_bit = (bits_inc == num_bits_reg);
    assign word_done = (pack_cnt_reg == PC_W'(OUT_WIDTH - 1)) | last_bit;

    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_pack
            assign pack_next[gi] = (pack_cnt_reg == PC_W'(gi)) ? d_bit : pack_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            scr_reg            <= '0;
            seed_cnt_reg       <= '0;
            skip_cnt_reg       <= '0;
            skip_len_reg       <= '0;
            num_bits_reg       <= '0;
            desc_reg           <= 1'b0;
            bits_delivered_reg <= '0;
            pack_reg           <= '0;
            pack_cnt_reg       <= '0;
            push_vld_reg       <= 1'b0;
            push_last_reg      <= 1'b0;
            push_data_reg      <= '0;
            busy_reg           <= 1'b0;
        end else if (start) begin
            if (num_bits == '0) begin
                state_reg <= IDLE;
            end else if (do_descramble) begin
                state_reg <= SEED;
            end else if (skip_bits != 5'd0) begin
                state_reg <= SKIP;
            end else begin
                state_reg <= DATA;
            end
            desc_reg           <= do_descramble;
            skip_len_reg       <= skip_bits;
            num_bits_reg       <= num_bits;
            scr_reg            <= '0;
            seed_cnt_reg       <= '0;
            skip_cnt_reg       <= '0;
            bits_delivered_reg <= '0;
            pack_reg           <= '0;
            pack_cnt_reg       <= '0;
            push_vld_reg       <= 1'b0;
            push_last_reg      <= 1'b0;
            push_data_reg      <= '0;
            busy_reg           <= (num_bits != '0);
        end else begin
            push_vld_reg <= 1'b0;
            // busy drops on the same edge that hands the final word to the FIFO.
            if (push_vld_reg && push_last_reg) begin
                busy_reg <= 1'b0;
            end
            if (stb) begin
                case (state_reg)
                    SEED: begin
                        scr_reg      <= {scr_reg[5:0], bit_in};
                        seed_cnt_reg <= seed_cnt_reg + 3'd1;
                        if (seed_cnt_reg == 3'd6) begin
                            state_reg <= (skip_len_reg != 5'd0) ? SKIP : DATA;
                        end
                    end
                    SKIP: begin
                        scr_reg      <= scr_desc;
                        skip_cnt_reg <= skip_cnt_reg + 5'd1;
                        if (skip_cnt_reg == skip_len_reg - 5'd1) begin
                            state_reg <= DATA;
                        end
                    end
                    DATA: begin
                        scr_reg            <= scr_desc;
                        bits_delivered_reg <= bits_inc;
                        if (word_done) begin
                            push_vld_reg  <= 1'b1;
                            push_last_reg <= last_bit;
                            push_data_reg <= pack_next;
                            pack_reg      <= '0;
                            pack_cnt_reg  <= '0;
                        end else begin
                            pack_reg     <= pack_next;
                            pack_cnt_reg <= pack_cnt_reg + PC_W'(1);
                        end
                        if (last_bit) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output FIFO: first-word fall-through, head read straight from the array.
    logic [OUT_WIDTH:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [FC_W-1:0]    count_reg;
    logic               overflow_reg;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic [OUT_WIDTH:0] head;

    assign fifo_full = (count_reg == FC_W'(FIFO_DEPTH));
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_vld_reg & (~fifo_full | pop);
    assign head      = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_ok && !start) begin
            fifo_mem[wr_ptr_reg] <= {push_last_reg, push_data_reg};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + FC_W'(1);
            end else if (!push_ok && pop) begin
                count_reg <= count_reg - FC_W'(1);
            end
            if (push_vld_reg && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_data       = out_valid ? head[OUT_WIDTH-1:0] : '0;
    assign out_last       = out_valid & head[OUT_WIDTH];
    assign busy           = busy_reg;
    assign overflow       = overflow_reg;
    assign bits_delivered = bits_delivered_reg;

endmodule

// File: doc/ofdm_bit_sink.md
# ofdm_bit_sink

Parametrised bit-to-word back end for the OFDM receive chain. It sits after the Viterbi decoder and turns its serial output into a framed word stream. It does four things:
- recovers the 802.11 descrambler seed from the SERVICE field;
- drops a programmable number of service bits;
- packs a programmable number of payload bits into OUT_WIDTH-bit words;
- presents them on a ready/valid interface through a small FIFO with an end-of-frame flag.

It replaces the fixed skip-9 / byte-packing path of the decoder top level.

## Interface
Parameters:
- OUT_WIDTH, 8, output word width in bits (1..32).
- FIFO_DEPTH, 4, output FIFO depth in words (power of 2, ≥2).
- CNT_WIDTH, 20, width of the payload bit counter.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when low, bit_in_stb is ignored; the output handshake keeps running.
- start  in  1  one-cycle pulse: arm a new frame and latch do_descramble, skip_bits and num_bits.
- do_descramble  in  1  1 = seed recovery plus descrambling; 0 = bits pass through unchanged.
- skip_bits  in  5  number of post-seed bits to discard.
- num_bits  in  CNT_WIDTH  number of payload bits to deliver.
- bit_in  in  1  decoded bit.
- bit_in_stb  in  1  bit_in is valid this cycle.
- out_data  out  OUT_WIDTH  packed word, LSB = earliest bit.
- out_valid  out  1  FIFO head is valid.
- out_last  out  1  qualifies out_data as the final word of the frame.
- out_ready  in  1  consumer accepts the head word.
- busy  out  1  high from start until the last word is written into the FIFO.
- overflow  out  1  sticky: a word was dropped because the FIFO was full. Cleared by start.
- bits_delivered  out  CNT_WIDTH  payload bits packed so far in the current frame.

## Operation
- **Reset values:** every output is 0, the FIFO is empty and the state is IDLE.
- **States:** IDLE, SEED, SKIP, DATA. In IDLE, strobes are ignored.
- **start handling:**
  - start is legal in any state. It aborts the current frame, flushes the FIFO, clears the pack register, bits_delivered and overflow, and loads the scrambler state with 0.
  - Next state: SEED if do_descramble=1; otherwise SKIP if skip_bits>0; otherwise DATA.
  - If num_bits=0, the frame ends immediately: state returns to IDLE, busy stays 0 and nothing is emitted.
- **SEED:**
  - Each strobe shifts bit_in into the scrambler state: state <= {state[5:0], bit_in}.
  - After 7 strobes, go to SKIP if skip_bits>0, else DATA.
  - Seed bits are never delivered.
- **Descrambled bit d:**
  - fb = state[6]^state[3].
  - d = bit_in^fb.
  - state <= {state[5:0], fb}.
  - When do_descramble=0, d = bit_in and the state is unchanged.
- **SKIP:** each strobe computes d and discards it. After skip_bits strobes, go to DATA.
- **DATA:**
  - Each strobe writes d into pack bit position bits_delivered mod OUT_WIDTH, and bits_delivered increments.
  - A word completes when OUT_WIDTH bits are collected, or when bits_delivered reaches num_bits. In the second case the unused upper bits are 0 and out_last=1.
  - After the last bit, go to IDLE. Further strobes are ignored until the next start.
- **FIFO:**
  - First-word fall-through.
  - A word is popped on out_valid & out_ready.
  - A completed word that arrives while the FIFO is full and not popping in the same cycle is dropped and overflow is set.
  - The state machine and count still advance on a drop.
  - Simultaneous push and pop when full is accepted.
- **Simultaneous start and bit_in_stb:** start wins and the bit is discarded.

## Timing
- Strobe sampled at edge E → pack register and count updated at E.
- A completed word is written at E+1 and shown on out_valid/out_data/out_last after E+1. That is 2 cycles from the strobe-high cycle to out_valid.
- Back-to-back strobes (one per cycle) are sustained with no bubbles.
- busy falls at the edge that writes the last word into the FIFO.
- reset asserted mid-frame clears everything immediately, asynchronously. Deassertion is synchronised internally to clock.

## Test plan
- **Seed recovery.** OUT_WIDTH=8, do_descramble=1, skip_bits=0, num_bits=8. Send seven 1s, then 0,0,0,0,1,1,1,0 (first to last). Required: one word 0x00, out_last=1.
- **Descrambler sequence.** Same setup, but send eight 0s after the 7-ones seed. Required: out_data=0x70, out_last=1.
- **Pass-through with skip and partial word.** do_descramble=0, skip_bits=9, num_bits=12. Send 9 junk bits, then 1,0,1,1,0,0,0,0,1,1,1,1. Required: words 0x0D then 0x0F (last=1), bits_delivered=12, busy low after the second write.
- **Backpressure and overflow.** FIFO_DEPTH=4, num_bits=48, out_ready=0. Required: 4 words held, word 5 dropped, overflow=1. Then raise out_ready: exactly 4 words drain. A following start clears overflow.
- **Abort.** Issue start mid-DATA while 2 words are queued. Required: FIFO empty and out_valid=0 the next cycle, new frame decoded correctly. Also check num_bits=0: no output and busy never rises.
- **Reset mid-frame and enable.** Assert reset mid-frame: all outputs 0 immediately. Then hold enable=0 during 5 strobes: no count change.
